weight_buffer_db: RTL and testbench
===================================

// Module: weight_buffer_db
// PURPOSE
//  Double-buffered twiddle-weight store for the full-parallel FFT. A serial
//  stream of complex weights loads a shadow register bank through a valid/ready
//  handshake. A full bank is committed atomically to the active bank that drives
//  the butterfly array. Weights for the next transform can load while the current
//  transform still uses the active set.
// PARAMETERS
//  NPOINT     3   log2 of FFT size
//  WIDTH      16  bits per real/imag component
//  AUTO_SWAP  0   1: commit automatically on full; 0: commit only on swap_req
//  NWEIGHT    (localparam) NPOINT*2**(NPOINT-1), number of weight slots
// PORTS
//  clk             in   1               clock, rising edge
//  rst             in   1               async reset, active-high
//  clear           in   1               discard shadow contents, restart load
//  swap_req        in   1               request shadow->active commit
//  din_valid       in   1               input weight valid
//  din_ready       out  1               buffer accepts input this cycle
//  din_real        in   WIDTH           input weight real part
//  din_imag        in   WIDTH           input weight imag part
//  load_count      out  clog2(NWEIGHT+1) words held in shadow bank
//  shadow_full     out  1               shadow bank holds NWEIGHT words
//  swap_done       out  1               one-cycle pulse, active bank updated
//  weight_valid    out  1               active bank holds a committed set
//  weight_real     out  NWEIGHT*WIDTH   active real weights, slot i = [i*WIDTH +: WIDTH]
//  weight_imag     out  NWEIGHT*WIDTH   active imag weights, same slot layout
// BEHAVIOUR
//  Reset: all outputs and both banks zero; state LOAD; load_count=0; din_ready=1.
//  States: LOAD (din_ready=1) and FULL (din_ready=0).
//  LOAD: a word is accepted when din_valid&&din_ready.
//   - Shadow real and imag banks both shift left one slot; the new word enters slot 0.
//   - load_count increments.
//   - On acceptance of word NWEIGHT-1, go to FULL; shadow_full=1 from the next cycle.
//  Slot order after a full load: arrival index k (0-based) sits in slot NWEIGHT-1-k.
//  FULL: din_valid is ignored and the shadow bank holds.
//   - Commit fires when swap_req=1 (AUTO_SWAP=0), or on the first FULL cycle (AUTO_SWAP=1).
//   - At that edge: active<=shadow, weight_valid<=1, load_count<=0, state<=LOAD.
//   - swap_done pulses high for the following cycle.
//   - The shadow bank is not cleared; the next load overwrites it by shifting.
//  swap_req in LOAD is ignored and is not remembered.
//  Latency: weight_real/imag change exactly 1 clk after the commit edge condition.
//   - They never change at any other time except reset.
//  clear (any state): load_count<=0, state<=LOAD, shadow contents don't-care.
//   - Active bank and weight_valid are unchanged.
//   - clear has priority over a commit and over input acceptance in the same cycle.
//  A word presented with clear=1 is not accepted; din_ready stays 1 in that cycle.
//  Reset asserted mid-load or in FULL returns everything to the reset state at once.
//  No arithmetic is performed; all data are passed bit-exact.
// TESTING  (NPOINT=3 -> NWEIGHT=12, WIDTH=16)
//  1. Reset: rst=1 -> weight_real/imag=0, weight_valid=0, din_ready=1, load_count=0.
//  2. Load real=k, imag=0x100+k for k=0..11, then swap_req=1 (AUTO_SWAP=0)
//     -> slot 11=0/0x100, slot 0=11/0x10B, swap_done pulses once, weight_valid=1.
//  3. Push a 13th word while FULL -> din_ready=0, word dropped, shadow unchanged,
//     load_count=12.
//  4. Commit set A, load 12 words of set B without swap -> outputs still show A;
//     after swap_req they show B.
//  5. Load 5 words, assert clear together with din_valid
//     -> load_count=0, active unchanged; the next 12 words load cleanly.
//  6. AUTO_SWAP=1: stream 12 words with din_valid held high
//     -> commit 1 cycle after the 12th, swap_done=1, din_ready=1 again,
//        and a 13th word is accepted as arrival 0 of the next set.

Source files
------------

// File: rtl/weight_buffer_db.sv
// weight_buffer_db: double-buffered twiddle-weight store for the full-parallel FFT
//
// A serial stream of complex weights shifts into a shadow bank through a
// valid/ready handshake. Once the shadow bank is full it is committed atomically
// to the active bank driving the butterfly array, on swap_req or automatically
// when AUTO_SWAP=1. The next set can load while the active set stays in use.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous reset, active-high
//   clear         discard shadow contents and restart the load
//   swap_req      request a shadow->active commit
//   din_valid     input weight valid
//   din_ready     buffer accepts input this cycle
//   din_real      input weight real part
//   din_imag      input weight imaginary part
//   load_count    words held in the shadow bank
//   shadow_full   shadow bank holds NWEIGHT words
//   swap_done     one-cycle pulse after the active bank is updated
//   weight_valid  active bank holds a committed set
//   weight_real   active real weights, slot i = [i*WIDTH +: WIDTH]
//   weight_imag   active imaginary weights, same slot layout
module weight_buffer_db #(
   parameter int NPOINT    = 3,
   parameter int WIDTH     = 16,
   parameter int AUTO_SWAP = 0,
   localparam int NWEIGHT  = NPOINT * (2 ** (NPOINT - 1)),
   localparam int CW       = $clog2(NWEIGHT + 1),
   localparam int SW       = NWEIGHT * WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          swap_req,
   input  logic          din_valid,
   output logic          din_ready,
   input  logic [WIDTH-1:0] din_real,
   input  logic [WIDTH-1:0] din_imag,
   output logic [CW-1:0] load_count,
   output logic          shadow_full,
   output logic          swap_done,
   output logic          weight_valid,
   output logic [SW-1:0] weight_real,
   output logic [SW-1:0] weight_imag
);

   typedef enum logic {S_LOAD, S_FULL} state_t;

   state_t        r_state;
   state_t        w_state_nx;
   logic [CW-1:0] r_count;
   logic [SW-1:0] r_sh_real;
   logic [SW-1:0] r_sh_imag;
   logic [SW-1:0] r_act_real;
   logic [SW-1:0] r_act_imag;
   logic          r_valid;
   logic          r_done;
   logic          w_accept;
   logic          w_commit;
   logic          w_last;

   assign w_last = r_count == CW'(NWEIGHT - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_LOAD;
      else     r_state <= w_state_nx;
   end

   // clear wins over both the load-complete and the commit transitions
   always_comb begin
      w_state_nx = r_state;
      if (clear)                       w_state_nx = S_LOAD;
      else if (w_accept && w_last)     w_state_nx = S_FULL;
      else if (w_commit)               w_state_nx = S_LOAD;
   end

   // with AUTO_SWAP the commit fires on the first FULL cycle, which is also the only one
   always_comb begin
      din_ready = r_state == S_LOAD;
      w_accept  = din_ready && din_valid && !clear;
      w_commit  = r_state == S_FULL && !clear && (AUTO_SWAP != 0 || swap_req);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count    <= '0;
         r_sh_real  <= '0;
         r_sh_imag  <= '0;
         r_act_real <= '0;
         r_act_imag <= '0;
         r_valid    <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= w_commit;
         if (clear || w_commit) r_count <= '0;
         else if (w_accept)     r_count <= r_count + CW'(1);
         // newest word enters slot 0, so arrival k ends in slot NWEIGHT-1-k
         if (w_accept) begin
            r_sh_real <= (r_sh_real << WIDTH) | SW'(din_real);
            r_sh_imag <= (r_sh_imag << WIDTH) | SW'(din_imag);
         end
         if (w_commit) begin
            r_act_real <= r_sh_real;
            r_act_imag <= r_sh_imag;
            r_valid    <= 1'b1;
         end
      end
   end

   assign load_count   = r_count;
   assign shadow_full  = r_count == CW'(NWEIGHT);
   assign swap_done    = r_done;
   assign weight_valid = r_valid;
   assign weight_real  = r_act_real;
   assign weight_imag  = r_act_imag;

endmodule

// File: tb/tb_weight_buffer_db.sv
// tb_weight_buffer_db: randomized self-checking bench with a slot-array reference model
module tb_weight_buffer_db;

   localparam int NW = 12;
   localparam int W  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          clear = 0, swap_req = 0, din_valid = 0, din_ready;
   logic [W-1:0]  din_real = 0, din_imag = 0;
   logic [3:0]    load_count;
   logic          shadow_full, swap_done, weight_valid;
   logic [NW*W-1:0] weight_real, weight_imag;

   logic          a_clear = 0, a_swap = 0, a_valid = 0, a_ready;
   logic [W-1:0]  a_real = 0, a_imag = 0;
   logic [3:0]    a_count;
   logic          a_full, a_done, a_wvalid;
   logic [NW*W-1:0] a_wreal, a_wimag;

   weight_buffer_db #(.NPOINT(3), .WIDTH(W), .AUTO_SWAP(0)) dut (
      .clk(clk), .rst(rst), .clear(clear), .swap_req(swap_req),
      .din_valid(din_valid), .din_ready(din_ready), .din_real(din_real), .din_imag(din_imag),
      .load_count(load_count), .shadow_full(shadow_full), .swap_done(swap_done),
      .weight_valid(weight_valid), .weight_real(weight_real), .weight_imag(weight_imag));

   weight_buffer_db #(.NPOINT(3), .WIDTH(W), .AUTO_SWAP(1)) dut_auto (
      .clk(clk), .rst(rst), .clear(a_clear), .swap_req(a_swap),
      .din_valid(a_valid), .din_ready(a_ready), .din_real(a_real), .din_imag(a_imag),
      .load_count(a_count), .shadow_full(a_full), .swap_done(a_done),
      .weight_valid(a_wvalid), .weight_real(a_wreal), .weight_imag(a_wimag));

   int checks = 0;
   int failures = 0;

   logic [W-1:0] q_r[$], q_i[$];
   logic [W-1:0] act_r[NW], act_i[NW];
   int m_cnt;
   bit m_valid, m_done;

   function automatic void model_reset();
      m_cnt = 0; m_valid = 0; m_done = 0;
      q_r.delete(); q_i.delete();
      for (int i = 0; i < NW; i++) begin act_r[i] = 0; act_i[i] = 0; end
   endfunction

   function automatic logic [NW*W-1:0] exp_w(input bit im);
      logic [NW*W-1:0] e;
      for (int i = 0; i < NW; i++) e[i*W +: W] = im ? act_i[i] : act_r[i];
      return e;
   endfunction

   task automatic drive(input bit v, input logic [W-1:0] r, input logic [W-1:0] im, input bit c, input bit s);
      din_valid = v; din_real = r; din_imag = im; clear = c; swap_req = s;
      @(posedge clk);
      m_done = 0;
      if (c) m_cnt = 0;
      else if (m_cnt == NW) begin
         if (s) begin
            for (int i = 0; i < NW; i++) begin act_r[i] = q_r[NW-1-i]; act_i[i] = q_i[NW-1-i]; end
            m_valid = 1; m_cnt = 0; m_done = 1;
         end
      end else if (v) begin
         q_r.push_back(r); q_i.push_back(im);
         if (q_r.size() > NW) begin void'(q_r.pop_front()); void'(q_i.pop_front()); end
         m_cnt++;
      end
      #1;
      din_valid = 0; clear = 0; swap_req = 0;
   endtask

   task automatic load_rand(input int n);
      for (int k = 0; k < n; k++) drive(1, W'($urandom), W'($urandom), 0, 0);
   endtask

   task automatic test_reset();
      rst = 1; model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (weight_real !== '0) begin failures++; $display("FAIL reset_real got %h exp 0", weight_real); end
      checks++; if (weight_imag !== '0) begin failures++; $display("FAIL reset_imag got %h exp 0", weight_imag); end
      checks++; if (weight_valid !== 1'b0) begin failures++; $display("FAIL reset_wvalid got %b exp 0", weight_valid); end
      checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", din_ready); end
      checks++; if (load_count !== 4'd0) begin failures++; $display("FAIL reset_count got %0d exp 0", load_count); end
      checks++; if (shadow_full !== 1'b0) begin failures++; $display("FAIL reset_full got %b exp 0", shadow_full); end
      checks++; if (swap_done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", swap_done); end
      rst = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_load_swap();
      for (int k = 0; k < NW; k++) drive(1, W'(k), W'(16'h100 + k), 0, 0);
      checks++; if (load_count !== 4'd12) begin failures++; $display("FAIL ls_count got %0d exp 12", load_count); end
      checks++; if (shadow_full !== 1'b1) begin failures++; $display("FAIL ls_full got %b exp 1", shadow_full); end
      checks++; if (din_ready !== 1'b0) begin failures++; $display("FAIL ls_ready got %b exp 0", din_ready); end
      checks++; if (weight_valid !== 1'b0) begin failures++; $display("FAIL ls_wvalid_pre got %b exp 0", weight_valid); end
      drive(0, 0, 0, 0, 1);
      checks++; if (swap_done !== 1'b1) begin failures++; $display("FAIL ls_done got %b exp 1", swap_done); end
      checks++; if (weight_valid !== 1'b1) begin failures++; $display("FAIL ls_wvalid got %b exp 1", weight_valid); end
      checks++; if (weight_real[11*W +: W] !== 16'h0000 || weight_imag[11*W +: W] !== 16'h0100) begin failures++; $display("FAIL ls_slot11 got %h/%h exp 0000/0100", weight_real[11*W +: W], weight_imag[11*W +: W]); end
      checks++; if (weight_real[0 +: W] !== 16'h000B || weight_imag[0 +: W] !== 16'h010B) begin failures++; $display("FAIL ls_slot0 got %h/%h exp 000b/010b", weight_real[0 +: W], weight_imag[0 +: W]); end
      checks++; if (weight_real !== exp_w(0) || weight_imag !== exp_w(1)) begin failures++; $display("FAIL ls_bank got %h exp %h", weight_real, exp_w(0)); end
      drive(0, 0, 0, 0, 0);
      checks++; if (swap_done !== 1'b0) begin failures++; $display("FAIL ls_done_pulse got %b exp 0", swap_done); end
      checks++; if (load_count !== 4'd0 || din_ready !== 1'b1) begin failures++; $display("FAIL ls_restart got %0d/%b exp 0/1", load_count, din_ready); end
   endtask

   task automatic test_full_drop();
      load_rand(NW);
      checks++; if (din_ready !== 1'b0) begin failures++; $display("FAIL fd_ready got %b exp 0", din_ready); end
      drive(1, 16'hDEAD, 16'hBEEF, 0, 0);
      checks++; if (load_count !== 4'd12) begin failures++; $display("FAIL fd_count got %0d exp 12", load_count); end
      checks++; if (weight_real !== exp_w(0)) begin failures++; $display("FAIL fd_active got %h exp %h", weight_real, exp_w(0)); end
      drive(0, 0, 0, 0, 1);
      checks++; if (weight_real !== exp_w(0) || weight_imag !== exp_w(1)) begin failures++; $display("FAIL fd_shadow got %h exp %h", weight_real, exp_w(0)); end
   endtask

   task automatic test_no_swap();
      load_rand(NW);
      repeat (3) drive(0, 0, 0, 0, 0);
      checks++; if (weight_real !== exp_w(0) || weight_imag !== exp_w(1)) begin failures++; $display("FAIL ns_hold got %h exp %h", weight_real, exp_w(0)); end
      checks++; if (swap_done !== 1'b0) begin failures++; $display("FAIL ns_nodone got %b exp 0", swap_done); end
      drive(0, 0, 0, 0, 1);
      checks++; if (weight_real !== exp_w(0) || weight_imag !== exp_w(1)) begin failures++; $display("FAIL ns_swap got %h exp %h", weight_real, exp_w(0)); end
      checks++; if (swap_done !== 1'b1) begin failures++; $display("FAIL ns_done got %b exp 1", swap_done); end
   endtask

   task automatic test_clear();
      drive(0, 0, 0, 0, 1);
      checks++; if (swap_done !== 1'b0) begin failures++; $display("FAIL cl_swap_in_load got %b exp 0", swap_done); end
      load_rand(5);
      drive(1, 16'h1234, 16'h5678, 1, 0);
      checks++; if (load_count !== 4'd0) begin failures++; $display("FAIL cl_count got %0d exp 0", load_count); end
      checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL cl_ready got %b exp 1", din_ready); end
      checks++; if (weight_real !== exp_w(0) || weight_valid !== 1'b1) begin failures++; $display("FAIL cl_active got %h exp %h", weight_real, exp_w(0)); end
      load_rand(NW);
      drive(0, 0, 0, 1, 1);
      checks++; if (swap_done !== 1'b0 || load_count !== 4'd0) begin failures++; $display("FAIL cl_prio got %b/%0d exp 0/0", swap_done, load_count); end
      checks++; if (weight_real !== exp_w(0)) begin failures++; $display("FAIL cl_prio_active got %h exp %h", weight_real, exp_w(0)); end
      load_rand(NW);
      drive(0, 0, 0, 0, 1);
      checks++; if (weight_real !== exp_w(0) || weight_imag !== exp_w(1)) begin failures++; $display("FAIL cl_reload got %h exp %h", weight_real, exp_w(0)); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(3, 0) != 0, W'($urandom), W'($urandom), $urandom_range(24, 0) == 0, $urandom_range(2, 0) == 0);
         checks++; if (din_ready !== (m_cnt != NW)) begin failures++; $display("FAIL rnd_ready[%0d] got %b exp %b", n, din_ready, m_cnt != NW); end
         checks++; if (load_count !== 4'(m_cnt)) begin failures++; $display("FAIL rnd_count[%0d] got %0d exp %0d", n, load_count, m_cnt); end
         checks++; if (shadow_full !== (m_cnt == NW)) begin failures++; $display("FAIL rnd_full[%0d] got %b exp %b", n, shadow_full, m_cnt == NW); end
         checks++; if (swap_done !== m_done) begin failures++; $display("FAIL rnd_done[%0d] got %b exp %b", n, swap_done, m_done); end
         checks++; if (weight_valid !== m_valid) begin failures++; $display("FAIL rnd_wvalid[%0d] got %b exp %b", n, weight_valid, m_valid); end
         checks++; if (weight_real !== exp_w(0)) begin failures++; $display("FAIL rnd_real[%0d] got %h exp %h", n, weight_real, exp_w(0)); end
         checks++; if (weight_imag !== exp_w(1)) begin failures++; $display("FAIL rnd_imag[%0d] got %h exp %h", n, weight_imag, exp_w(1)); end
      end
   endtask

   task automatic test_async_reset();
      load_rand(4);
      #3 rst = 1;
      #1;
      model_reset();
      checks++; if (load_count !== 4'd0 || din_ready !== 1'b1) begin failures++; $display("FAIL ar_count got %0d/%b exp 0/1", load_count, din_ready); end
      checks++; if (weight_valid !== 1'b0 || weight_real !== '0 || weight_imag !== '0) begin failures++; $display("FAIL ar_active got %b/%h exp 0/0", weight_valid, weight_real); end
      @(posedge clk); #1 rst = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_auto_swap();
      logic [W-1:0] wr[24], wi[24];
      logic [NW*W-1:0] er, ei;
      for (int k = 0; k < 24; k++) begin wr[k] = W'($urandom); wi[k] = W'($urandom); end
      for (int k = 0; k < NW; k++) begin
         a_valid = 1; a_real = wr[k]; a_imag = wi[k];
         @(posedge clk); #1;
      end
      checks++; if (a_count !== 4'd12 || a_ready !== 1'b0) begin failures++; $display("FAIL au_full got %0d/%b exp 12/0", a_count, a_ready); end
      a_real = wr[12]; a_imag = wi[12];
      @(posedge clk); #1;
      for (int i = 0; i < NW; i++) begin er[i*W +: W] = wr[NW-1-i]; ei[i*W +: W] = wi[NW-1-i]; end
      checks++; if (a_done !== 1'b1 || a_ready !== 1'b1) begin failures++; $display("FAIL au_commit got %b/%b exp 1/1", a_done, a_ready); end
      checks++; if (a_wvalid !== 1'b1 || a_count !== 4'd0) begin failures++; $display("FAIL au_state got %b/%0d exp 1/0", a_wvalid, a_count); end
      checks++; if (a_wreal !== er || a_wimag !== ei) begin failures++; $display("FAIL au_bank got %h exp %h", a_wreal, er); end
      @(posedge clk); #1;
      checks++; if (a_count !== 4'd1 || a_done !== 1'b0) begin failures++; $display("FAIL au_next got %0d/%b exp 1/0", a_count, a_done); end
      for (int k = 13; k < 24; k++) begin
         a_real = wr[k]; a_imag = wi[k];
         @(posedge clk); #1;
      end
      a_valid = 0;
      @(posedge clk); #1;
      for (int i = 0; i < NW; i++) begin er[i*W +: W] = wr[23-i]; ei[i*W +: W] = wi[23-i]; end
      checks++; if (a_wreal[11*W +: W] !== wr[12]) begin failures++; $display("FAIL au_arrival0 got %h exp %h", a_wreal[11*W +: W], wr[12]); end
      checks++; if (a_wreal !== er || a_wimag !== ei || a_done !== 1'b1) begin failures++; $display("FAIL au_bank2 got %h exp %h", a_wreal, er); end
   endtask

   initial begin
      test_reset();
      test_load_swap();
      test_full_drop();
      test_no_swap();
      test_clear();
      test_random();
      test_async_reset();
      test_auto_swap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
